// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO drain arbiter:
// FSM state encodings and default sizing.
package fifo_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } arbState_t;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 6;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first eligible requester
// starting at ptr and wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int cand;

  // Scan ptr, ptr+1, ... and keep the first eligible hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && eligible[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining N FWFT input FIFOs into one output FIFO.
// One pop per cycle; the popped head is registered toward the output FIFO.
// Optional per-FIFO saturating grant counters: define ARB_GRANT_CNT_EN.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PTR_W  = $clog2(N)
`ifdef ARB_GRANT_CNT_EN
  ,
  parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                iniciar,
  input  logic [N-1:0]        empty,
  input  logic [N-1:0]        pausa,
  input  logic                stall,
  input  logic [N*DATA_W-1:0] data_in,
  output logic [N-1:0]        pop,
  output logic                push_out,
  output logic [DATA_W-1:0]   data_out,
  output logic [PTR_W-1:0]    sel,
  output logic                idle
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [N*CNT_W-1:0]  grant_cnt
`endif
);

  arbState_t          state, nextState;
  logic [PTR_W-1:0]   ptr;
  logic [N-1:0]       eligible;
  logic [N-1:0]       pickGrant;
  logic [PTR_W-1:0]   pickIdx;
  logic               pickAny;
  logic               doGrant;

  function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  assign eligible = ~empty & ~pausa;

  rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) uPick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (pickGrant),
    .idx      (pickIdx),
    .any      (pickAny)
  );

  // Next-state and pop decode; stall and pausa act within the same cycle.
  always_comb begin
    nextState = state;
    pop       = '0;
    doGrant   = 1'b0;
    if (!rst) begin
      case (state)
        INIT: begin
          if (enb && iniciar) nextState = ACTIVE;
        end
        ACTIVE: begin
          if (stall) begin
            if (enb) nextState = HOLD;
          end else if (enb && pickAny) begin
            pop     = pickGrant;
            doGrant = 1'b1;
          end
        end
        HOLD: begin
          if (enb && !stall) nextState = ACTIVE;
        end
        default: nextState = INIT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= nextState;
  end

  // Grant stage -> output FIFO write stage: register the popped head.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      push_out <= 1'b0;
      data_out <= '0;
      sel      <= '0;
      idle     <= 1'b0;
    end else begin
      push_out <= doGrant;
      idle     <= (state == ACTIVE) && (&empty);
      if (doGrant) begin
        data_out <= data_in[pickIdx*DATA_W +: DATA_W];
        sel      <= pickIdx;
        ptr      <= wrapInc(pickIdx);
      end
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt [N];

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Per-FIFO grant counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (pop[i]) cnt[i] <= satInc(cnt[i]);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : gCnt
    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: directed scenarios followed by random traffic,
// with a queue-based scoreboard fed by a behavioural model.
module tb_fifo_rr_arbiter;

  localparam int N      = 4;
  localparam int DATA_W = 6;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 8;

  logic                clk;
  logic                rst, enb, iniciar, stall;
  logic [N-1:0]        empty, pausa, pop;
  logic [N*DATA_W-1:0] data_in;
  logic                push_out;
  logic [DATA_W-1:0]   data_out;
  logic [PTR_W-1:0]    sel;
  logic                idle;
`ifdef ARB_GRANT_CNT_EN
  logic [N*CNT_W-1:0]  grant_cnt;
`endif

  fifo_rr_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .iniciar  (iniciar),
    .empty    (empty),
    .pausa    (pausa),
    .stall    (stall),
    .data_in  (data_in),
    .pop      (pop),
    .push_out (push_out),
    .data_out (data_out),
    .sel      (sel),
    .idle     (idle)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int d; int s; } ent_t;
  ent_t q[$];

  int nTotal = 0;
  int nPass  = 0;
  bit monOn  = 0;

  // Model: mode 0 = waiting for start, 1 = draining, 2 = output stalled.
  int mMode = 0;
  int mPtr  = 0;
  int mCnt[N];
  bit ePush = 0;
  bit eIdle = 0;
  int eData = 0;
  int eSel  = 0;

  localparam logic [N*DATA_W-1:0] HEADS = {6'h0D, 6'h0C, 6'h0B, 6'h0A};

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void modelStep();
    logic [N-1:0] expPop;
    int g;
    expPop = '0;
    g = -1;
    if (!rst && mMode == 1 && !stall && enb)
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mPtr + k) % N;
        if (g < 0 && !empty[c] && !pausa[c]) g = c;
      end
    if (g >= 0) expPop[g] = 1'b1;
    chk("pop", 32'(pop), 32'(expPop));
    if (rst) begin
      mMode = 0; mPtr = 0; ePush = 0; eData = 0; eSel = 0; eIdle = 0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
      monOn = 1;
    end else begin
      eIdle = (mMode == 1) && (empty == '1);
      ePush = (g >= 0);
      if (g >= 0) begin
        ent_t e;
        e.d = int'(data_in[g*DATA_W +: DATA_W]);
        e.s = g;
        q.push_back(e);
        eData = e.d;
        eSel  = g;
        mPtr  = (g + 1) % N;
        if (mCnt[g] < (1 << CNT_W) - 1) mCnt[g]++;
      end
      if (enb) begin
        if (mMode == 0 && iniciar) mMode = 1;
        else if (mMode == 1 && stall) mMode = 2;
        else if (mMode == 2 && !stall) mMode = 1;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit ini, input logic [N-1:0] emp,
                     input logic [N-1:0] pau, input bit st, input logic [N*DATA_W-1:0] d);
    @(posedge clk);
    #1;
    rst = r; enb = e; iniciar = ini; empty = emp; pausa = pau; stall = st; data_in = d;
    #3;
    modelStep();
  endtask

  // Monitor: registered outputs checked after each edge against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (monOn) begin
        chk("push_out", 32'(push_out), 32'(ePush));
        if (push_out === 1'b1) begin
          if (q.size() == 0) begin
            chk("orphan_push", 32'(push_out), 32'd0);
          end else begin
            ent_t e;
            e = q.pop_front();
            chk("sb_data", 32'(data_out), 32'(e.d));
            chk("sb_sel", 32'(sel), 32'(e.s));
          end
        end
        chk("data_out", 32'(data_out), 32'(eData));
        chk("sel", 32'(sel), 32'(eSel));
        chk("idle", 32'(idle), 32'(eIdle));
`ifdef ARB_GRANT_CNT_EN
        for (int i = 0; i < N; i++)
          chk("grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(mCnt[i]));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; enb = 1'b0; iniciar = 1'b0; empty = '1; pausa = '0; stall = 1'b0; data_in = '0;

    // Reset, then stay in INIT without iniciar.
    cyc(1, 1, 0, '1, 4'b0000, 0, '0);
    cyc(1, 1, 0, '1, 4'b0000, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'b0000, 4'b0000, 0, HEADS);

    // Start and drain all four in order.
    cyc(0, 1, 1, 4'b0000, 4'b0000, 0, HEADS);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 4'b0000, 4'b0000, 0, HEADS);

    // FIFO 1 paused.
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 4'b0000, 4'b0010, 0, HEADS);

    // Grant FIFO 1, then stall; pointer must survive HOLD.
    cyc(0, 1, 0, 4'b1101, 4'b0000, 0, HEADS);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'b0000, 4'b0000, 1, HEADS);
    cyc(0, 1, 0, 4'b0000, 4'b0000, 0, HEADS);
    cyc(0, 1, 0, 4'b0000, 4'b0000, 0, HEADS);
    chk("ptr_retained", 32'(pop), 32'(4'b0100));

    // Single requester FIFO 3, then FIFO 0 joins right after the wrap.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 4'b0111, 4'b0000, 0, HEADS);
    cyc(0, 1, 0, 4'b0110, 4'b0000, 0, HEADS);
    chk("wrap_first", 32'(pop), 32'(4'b0001));
    cyc(0, 1, 0, 4'b0110, 4'b0000, 0, HEADS);

    // Reset while streaming; no grants until iniciar.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'b0000, 4'b0000, 0, HEADS);
    cyc(1, 1, 0, 4'b0000, 4'b0000, 0, HEADS);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'b0000, 4'b0000, 0, HEADS);
`ifdef ARB_GRANT_CNT_EN
    chk("cnt_cleared", 32'(grant_cnt), 32'd0);
`endif
    cyc(0, 1, 1, 4'b1011, 4'b0000, 0, HEADS);
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 4'b1011, 4'b0000, 0, HEADS);
    cyc(0, 1, 0, 4'b1111, 4'b0000, 0, HEADS);
`ifdef ARB_GRANT_CNT_EN
    chk("cnt_sat", 32'(grant_cnt[2*CNT_W +: CNT_W]), 32'd255);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit r, e, ini, st;
      logic [N-1:0] emp, pau;
      r   = ($urandom % 64) == 0;
      e   = ($urandom % 8) != 0;
      ini = ($urandom % 4) == 0;
      st  = ($urandom % 8) == 0;
      emp = N'($urandom);
      pau = (($urandom % 3) == 0) ? N'($urandom) : '0;
      cyc(r, e, ini, emp, pau, st, (N*DATA_W)'($urandom));
    end

    // Drain and confirm nothing is left outstanding.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '1, 4'b0000, 0, '0);
    chk("leftover", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
